// File: rtl/fetch_row_splitter.sv
// Splits fetch-queue rows into a one-instruction-per-cycle stream for decode.
// Each row is buffered once; its valid slots issue in ascending order, and the next row is prefetched.
module fetch_row_splitter #(
    parameter int INSTR_PER_ROW = 4,
    parameter int ENTRY_W       = 32,
    parameter int VALID_BIT     = ENTRY_W - 1,
    parameter int SLOT_W        = (INSTR_PER_ROW > 1) ? $clog2(INSTR_PER_ROW) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               q_empty_i,
    input  logic [INSTR_PER_ROW*ENTRY_W-1:0]   q_row_i,
    output logic                               q_pop_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [ENTRY_W-1:0]                 instr_o,
    output logic [SLOT_W-1:0]                  slot_o,
    output logic                               idle_o
);

    localparam logic [INSTR_PER_ROW-1:0] ONE = 1;

    typedef logic [ENTRY_W-1:0] entry_t;

    entry_t                   row_in [INSTR_PER_ROW];
    entry_t                   row_q  [INSTR_PER_ROW];
    entry_t                   row_d  [INSTR_PER_ROW];
    logic [INSTR_PER_ROW-1:0] row_valid;
    logic [INSTR_PER_ROW-1:0] pend_q;
    logic [INSTR_PER_ROW-1:0] pend_d;
    logic [INSTR_PER_ROW-1:0] low_bit;
    logic [SLOT_W-1:0]        slot;
    logic                     acc;
    logic                     last;
    logic                     pop;

    generate
        for (genvar gi = 0; gi < INSTR_PER_ROW; gi++) begin : g_slot
            assign row_in[gi]    = q_row_i[gi*ENTRY_W +: ENTRY_W];
            assign row_valid[gi] = q_row_i[gi*ENTRY_W + VALID_BIT];
            assign row_d[gi]     = pop ? row_in[gi] : row_q[gi];

            always_ff @(posedge clk_i) begin
                row_q[gi] <= row_d[gi];
            end
        end
    endgenerate

    // Descending scan so the lowest pending slot wins.
    always_comb begin
        slot = '0;
        for (int k = INSTR_PER_ROW - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                slot = SLOT_W'(k);
            end
        end
    end

    always_comb begin
        low_bit = pend_q & (~pend_q + ONE);
        valid_o = |pend_q;
        acc     = valid_o & ready_i;
        last    = acc & (pend_q == low_bit);
        pop     = ~q_empty_i & ~flush_i & ~rst_i & (~valid_o | last);
    end

    // Flush wins over accept; a pop replaces the mask even on the last accept.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end else if (pop) begin
            pend_d = row_valid;
        end else if (acc) begin
            pend_d = pend_q & ~low_bit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign q_pop_o = pop;
    assign slot_o  = slot;
    assign instr_o = row_q[slot];
    assign idle_o  = ~valid_o;

endmodule

// File: tb/tb_fetch_row_splitter.sv
// Directed and randomized bench for fetch_row_splitter against a queue-level reference model.
module tb_fetch_row_splitter;

    localparam int N  = 4;
    localparam int EW = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            q_empty_i;
    logic [N*EW-1:0] q_row_i;
    logic            q_pop_o;
    logic            valid_o;
    logic            ready_i;
    logic [EW-1:0]   instr_o;
    logic [1:0]      slot_o;
    logic            idle_o;

    always #5 clk = ~clk;

    fetch_row_splitter #(
        .INSTR_PER_ROW(N),
        .ENTRY_W      (EW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .q_empty_i(q_empty_i),
        .q_row_i  (q_row_i),
        .q_pop_o  (q_pop_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .instr_o  (instr_o),
        .slot_o   (slot_o),
        .idle_o   (idle_o)
    );

    logic [N*EW-1:0] fifo [$];
    logic [EW+1:0]   pend [$];
    int              checks = 0;
    int              errors = 0;
    int              row_id = 0;

    logic            obs_pop;
    logic            obs_valid;
    logic            obs_idle;
    logic            obs_acc;
    logic [1:0]      obs_slot;
    logic [EW-1:0]   obs_instr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_row(input logic [N-1:0] mask);
        logic [N*EW-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[k*EW +: EW] = {mask[k], 15'(row_id), 16'($urandom)};
        end
        fifo.push_back(r);
        row_id++;
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
    task automatic step(input logic r, input logic f, input logic rd, input logic he);
        logic            exp_pop;
        logic            exp_valid;
        logic [N*EW-1:0] head;
        rst_i     = r;
        flush_i   = f;
        ready_i   = rd;
        q_empty_i = he || (fifo.size() == 0);
        if (fifo.size() != 0) q_row_i = fifo[0];
        else                  q_row_i = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        exp_valid = (pend.size() != 0);
        exp_pop   = !q_empty_i && !f && !r && (pend.size() == 0 || (rd && pend.size() == 1));
        check("valid", 64'(valid_o), 64'(exp_valid));
        check("idle", 64'(idle_o), 64'(!exp_valid));
        check("pop", 64'(q_pop_o), 64'(exp_pop));
        if (exp_valid) begin
            check("instr", 64'(instr_o), 64'(pend[0][EW-1:0]));
            check("slot", 64'(slot_o), 64'(pend[0][EW+1:EW]));
        end
        obs_pop   = q_pop_o;
        obs_valid = valid_o;
        obs_idle  = idle_o;
        obs_slot  = slot_o;
        obs_instr = instr_o;
        obs_acc   = valid_o && rd;
        if (obs_acc)
            $display("t=%0t accept slot=%0d instr=%h%s", $time, slot_o, instr_o, f ? " flush" : "");
        if (r || f) begin
            pend.delete();
        end else if (exp_pop) begin
            head = fifo[0];
            pend.delete();
            for (int k = 0; k < N; k++) begin
                if (head[k*EW + EW - 1]) pend.push_back({2'(k), head[k*EW +: EW]});
            end
        end else if (rd && exp_valid) begin
            void'(pend.pop_front());
        end
        if (exp_pop) void'(fifo.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        int              pops;
        int              accepts;
        int              pop3;
        logic [N*EW-1:0] saved_row;
        logic [N*EW-1:0] saved_row2;
        logic [3:0]      sp_valid;
        logic [7:0]      sp_slot;

        rst_i     = 1'b1;
        flush_i   = 1'b0;
        ready_i   = 1'b0;
        q_empty_i = 1'b1;
        q_row_i   = '0;
        @(posedge clk);
        #1;

        // Reset held with a non-empty queue, then streaming of three full rows
        repeat (3) push_row(4'hF);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            check("rst_pop", 64'(obs_pop), 64'(0));
            check("rst_valid", 64'(obs_valid), 64'(0));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_release_pop", 64'(obs_pop), 64'(1));
        pops = 1; accepts = 0; pop3 = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("stream_slot", 64'(obs_slot), 64'(i % 4));
            pops    += int'(obs_pop);
            accepts += int'(obs_acc);
            if (obs_pop && obs_acc && obs_slot == 2'd3) pop3++;
        end
        check("stream_accepts", 64'(accepts), 64'(12));
        check("stream_pops", 64'(pops), 64'(3));
        check("stream_pop_on_slot3", 64'(pop3), 64'(2));

        // Last slot went with the queue empty: stays idle
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("empty_valid", 64'(obs_valid), 64'(0));
            check("empty_idle", 64'(obs_idle), 64'(1));
        end

        // Sparse rows: 1010, 0000, 0001
        push_row(4'b1010); push_row(4'b0000); push_row(4'b0001);
        sp_valid = 4'b1011;
        sp_slot  = {2'd0, 2'd0, 2'd3, 2'd1};
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            pops += int'(obs_pop);
            if (i > 0) begin
                check("sparse_valid", 64'(obs_valid), 64'(sp_valid[i-1]));
                if (sp_valid[i-1]) check("sparse_slot", 64'(obs_slot), 64'(sp_slot[2*(i-1) +: 2]));
            end
        end
        check("sparse_pops", 64'(pops), 64'(3));

        // Backpressure on slot 2
        push_row(4'hF);
        saved_row = fifo[fifo.size()-1];
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push_row(4'hF);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("bp_slot", 64'(obs_slot), 64'(2));
            check("bp_instr", 64'(obs_instr), 64'(saved_row[2*EW +: EW]));
            check("bp_pop", 64'(obs_pop), 64'(0));
            void'(fifo.pop_back());
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_resume_slot2", 64'(obs_slot), 64'(2));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_resume_slot3", 64'(obs_slot), 64'(3));
        check("bp_resume_instr", 64'(obs_instr), 64'(saved_row[3*EW +: EW]));

        // Flush while slot 1 is presented and accepted
        push_row(4'hF); push_row(4'hF);
        saved_row2 = fifo[1];
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_slot", 64'(obs_slot), 64'(1));
        check("flush_acc", 64'(obs_acc), 64'(1));
        check("flush_pop", 64'(obs_pop), 64'(0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("flush_next_valid", 64'(obs_valid), 64'(0));
        check("flush_next_pop", 64'(obs_pop), 64'(1));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("flush_row2_slot", 64'(obs_slot), 64'(0));
        check("flush_row2_instr", 64'(obs_instr), 64'(saved_row2[EW-1:0]));
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic with occasional flush, reset and withheld queue
        for (int i = 0; i < 400; i++) begin
            if (fifo.size() < 4 && $urandom_range(2) == 0) push_row(4'($urandom));
            step(($urandom_range(49) == 0), ($urandom_range(19) == 0),
                 ($urandom_range(3) != 0), ($urandom_range(4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_row_splitter.md
# fetch_row_splitter

Sits directly downstream of the fetch instruction queue and feeds the decode stage one instruction per cycle. Pops a full row of `INSTR_PER_ROW` fetch entries from the queue head and holds it in a single row buffer. Issues the row's valid slots in ascending slot order over a valid/ready handshake, skipping invalid slots. Prefetches the next row so a sustained stream flows at one instruction per cycle with no bubbles at row boundaries.

## Interface
- `INSTR_PER_ROW`, default `tortoise_pkg::INSTR_PER_FETCH`: slots per queue row; must be ≥ 1.
- `SLOT_W`, default `$clog2(INSTR_PER_ROW)` (minimum 1): width of the slot index output.

- `clk_i`  in  1  sole clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  discard the buffered row; no pop this cycle.
- `q_empty_i`  in  1  queue empty flag.
- `q_row_i`  in  `fetch_entry_t [INSTR_PER_ROW-1:0]`  queue head row (show-ahead, combinational).
- `q_pop_o`  out  1  pop the queue head this cycle.
- `valid_o`  out  1  `instr_o` holds an instruction.
- `ready_i`  in  1  decode accepts `instr_o` this cycle.
- `instr_o`  out  `fetch_entry_t`  current instruction, passed through unmodified.
- `slot_o`  out  `SLOT_W`  slot index of `instr_o` within its row.
- `idle_o`  out  1  row buffer holds no pending slot.

## Operation
- State:
  - row buffer `row_q` (`INSTR_PER_ROW` entries);
  - pending mask `pend_q` (`INSTR_PER_ROW` bits).
  - A slot is pending when its `pend_q` bit is set.
- Output selection: `valid_o = |pend_q`; `slot_o` is the lowest set bit of `pend_q`; `instr_o = row_q[slot_o]`.
- Accept: `acc = valid_o & ready_i`.
- Last slot: `last = acc` and exactly one `pend_q` bit is set.
- Pop rule: `q_pop_o = ~q_empty_i & ~flush_i & ~rst_i & (~valid_o | last)`.
- On pop:
  - `row_q <= q_row_i`;
  - `pend_q <= {q_row_i[k].valid}`.
  - A row with no valid slot loads an all-zero mask. It is consumed and dropped, and `valid_o` stays 0.
- Accept without pop: clear the `pend_q` bit at `slot_o`.
- Flush: `pend_q <= 0`.
  - Flush has priority over accept.
  - `row_q` is unchanged (don't-care).
  - An `acc` in the flush cycle still counts as a completed transfer to decode.
- Reset: `pend_q <= 0`. `row_q` is not reset.
- `idle_o = ~valid_o`.
- `instr_o` and `slot_o` must hold stable while `valid_o & ~ready_i`. Decode may stall indefinitely.

## Timing
- Reset values: `valid_o=0`, `idle_o=1`, `q_pop_o=0`. `slot_o` and `instr_o` are don't-care while `valid_o=0`.
- Latency: with the buffer idle, a row at the queue head in cycle t is popped in t. Its first valid slot appears on `instr_o` in t+1.
- Throughput: 1 instruction/cycle while `ready_i=1` and the queue is non-empty.
  - The row boundary costs no bubble: the next row is popped in the same cycle the last slot is accepted.
- Fully invalid row: costs one bubble cycle.
- Stall: with `ready_i=0` and `valid_o=1`, `q_pop_o=0` and all state holds.
- Flush in cycle t: `q_pop_o=0` in t, `valid_o=0` in t+1. Popping may resume in t+1.
- Reset asserted mid-row: pending slots are lost and `q_pop_o=0` while `rst_i=1`. The first pop may occur in the first cycle after `rst_i` deasserts.
- Queue empty while the last slot is accepted: no pop; `valid_o=0` next cycle.

## Test plan
Bench uses `INSTR_PER_ROW=4`.
- **Reset:** hold `rst_i` 3 cycles with `q_empty_i=0`.
  - `q_pop_o=0`, `valid_o=0` throughout.
  - First pop occurs in the first cycle after release.
- **Streaming:** 3 rows, all slots valid, `ready_i=1`.
  - 12 instructions on 12 consecutive cycles, slots 0,1,2,3,0,…
  - `q_pop_o` pulses exactly 3 times; the second and third pulses coincide with the slot-3 accepts.
- **Sparse rows:** valid masks 4'b1010, then 4'b0000, then 4'b0001.
  - Outputs are slot1, slot3, one bubble cycle, then slot0.
  - 3 pops total.
- **Backpressure:** `ready_i=0` for 5 cycles while slot 2 is presented.
  - `instr_o` and `slot_o=2` stable, `q_pop_o=0`.
  - Sequence resumes with slot 3 after `ready_i` returns.
- **Flush:** flush while slot 1 of 4 is presented with `ready_i=1`, queue non-empty.
  - Slot 1 is accepted; `q_pop_o=0` in the flush cycle; `valid_o=0` next cycle.
  - Slots 2–3 are never issued; the next row appears two cycles after the flush.
- **Empty queue:** last slot accepted with `q_empty_i=1`.
  - `valid_o=0`, `idle_o=1` from the next cycle until a row arrives.
